mvm_systolic_stream: RTL and testbench



---
 rtl/mvm_systolic_stream.sv | 256 +++++++++++++++++++++++++
 tb/tb_mvm_systolic_stream.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_systolic_stream.sv
// mvm_systolic_stream: weight-stationary systolic y = W.x with
// input skew, output deskew, streaming handshakes and drain-safe reload.

module mvm_systolic_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int ROWS       = 3,
  parameter int COLS       = 4,
  parameter int FRAC_BITS  = 14
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            load_matrix,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] matrix_in,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [COLS*DATA_WIDTH-1:0]      s_vector,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [ROWS*OUT_WIDTH-1:0]       m_result,
  output logic [ROWS-1:0]                 m_sat,
  output logic                            load_done
);

  localparam int PW        = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH = PW + $clog2(COLS);
  localparam int NTOK      = ROWS + COLS;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic signed [ACC_WIDTH-1:0]  acc_t;

  localparam acc_t SAT_HI =
    acc_t'({1'b0, {(OUT_WIDTH-1){1'b1}}});
  localparam acc_t SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_LOAD
  } state_e;

  state_e state_q, state_d;
  logic   load_done_q;

  logic            en;
  logic            accept;
  logic            busy;
  logic [NTOK-1:0] tok_q;

  logic                      m_valid_q;
  logic [ROWS*OUT_WIDTH-1:0] m_result_q;
  logic [ROWS-1:0]           m_sat_q;

  data_t w_q  [ROWS][COLS];
  data_t in_q [COLS];
  data_t xv   [ROWS][COLS];
  acc_t  pv   [ROWS][COLS];
  acc_t  dv   [ROWS];

  logic [ROWS*OUT_WIDTH-1:0] res_d;
  logic [ROWS-1:0]           sat_d;

  // A stalled output freezes the whole pipe.
  assign en      = m_ready || !m_valid_q;
  assign s_ready = en && (state_q == S_RUN);
  assign accept  = s_valid && s_ready;
  assign busy    = (|tok_q) || m_valid_q;

  // Reload sequencer next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (load_matrix) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!busy) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Sequencer state and one-cycle load-complete pulse
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_RUN;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= (state_q == S_LOAD);
    end
  end

  // Weights are captured only on the LOAD exit edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          w_q[i][j] <= '0;
    end else if (state_q == S_LOAD) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          w_q[i][j] <= data_t'(
            matrix_in[(i*COLS+j)*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Input register and valid tokens; bubbles load zeros
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tok_q <= '0;
      for (int j = 0; j < COLS; j++)
        in_q[j] <= '0;
    end else if (en) begin
      tok_q[0] <= accept;
      for (int k = 1; k < NTOK; k++)
        tok_q[k] <= tok_q[k-1];
      for (int j = 0; j < COLS; j++)
        in_q[j] <= accept
          ? data_t'(s_vector[j*DATA_WIDTH +: DATA_WIDTH])
          : '0;
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_skew
    if (j == 0) begin : g_direct
      assign xv[0][j] = in_q[j];
    end else begin : g_delay
      data_t sk_q [j];

      // Column j delay line, j stages deep
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          for (int k = 0; k < j; k++)
            sk_q[k] <= '0;
        end else if (en) begin
          sk_q[0] <= in_q[j];
          for (int k = 1; k < j; k++)
            sk_q[k] <= sk_q[k-1];
        end
      end

      assign xv[0][j] = sk_q[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [PW-1:0] prod;
      acc_t                 p_in;
      acc_t                 p_d;
      acc_t                 p_q;

      if (j == 0) begin : g_pfirst
        assign p_in = '0;
      end else begin : g_pchain
        assign p_in = pv[i][j-1];
      end

      assign prod = PW'(xv[i][j]) * PW'(w_q[i][j]);
      assign p_d  = p_in + acc_t'(prod);

      // Partial sum moves one column right per cycle
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          p_q <= '0;
        end else if (en) begin
          p_q <= p_d;
        end
      end

      assign pv[i][j] = p_q;

      if (i < ROWS - 1) begin : g_xpass
        data_t x_q;

        // Operand moves one row down per cycle
        always_ff @(posedge aclk or negedge aresetn) begin
          if (!aresetn) begin
            x_q <= '0;
          end else if (en) begin
            x_q <= xv[i][j];
          end
        end

        assign xv[i+1][j] = x_q;
      end
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_dsk
    localparam int D = ROWS - 1 - i;

    if (D == 0) begin : g_direct
      assign dv[i] = pv[i][COLS-1];
    end else begin : g_delay
      acc_t dk_q [D];

      // Row i waits for the later rows to finish
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          for (int k = 0; k < D; k++)
            dk_q[k] <= '0;
        end else if (en) begin
          dk_q[0] <= pv[i][COLS-1];
          for (int k = 1; k < D; k++)
            dk_q[k] <= dk_q[k-1];
        end
      end

      assign dv[i] = dk_q[D-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_fmt
    acc_t sh;
    logic hi;
    logic lo;

    assign sh = dv[i] >>> FRAC_BITS;
    assign hi = sh > SAT_HI;
    assign lo = sh < SAT_LO;

    assign res_d[i*OUT_WIDTH +: OUT_WIDTH] =
      hi ? SAT_HI[OUT_WIDTH-1:0] :
      lo ? SAT_LO[OUT_WIDTH-1:0] :
           sh[OUT_WIDTH-1:0];
    assign sat_d[i] = hi || lo;
  end

  // Output stage: loads finished vectors, holds under back-pressure
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q  <= 1'b0;
      m_result_q <= '0;
      m_sat_q    <= '0;
    end else if (en) begin
      m_valid_q <= tok_q[NTOK-1];
      if (tok_q[NTOK-1]) begin
        m_result_q <= res_d;
        m_sat_q    <= sat_d;
      end
    end
  end

  assign m_valid   = m_valid_q;
  assign m_result  = m_result_q;
  assign m_sat     = m_sat_q;
  assign load_done = load_done_q;

endmodule

// File: tb/tb_mvm_systolic_stream.sv
// tb_mvm_systolic_stream: directed bench for the 3x4 systolic
// matrix-vector multiplier, with a dot-product reference model.

module tb_mvm_systolic_stream;

  localparam int DW = 16;
  localparam int OW = 16;
  localparam int R  = 3;
  localparam int C  = 4;
  localparam int FB = 14;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b1;
  logic              load_matrix = 1'b0;
  logic [R*C*DW-1:0] matrix_in = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [C*DW-1:0]   s_vector = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [R*OW-1:0]   m_result;
  logic [R-1:0]      m_sat;
  logic              load_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  mvm_systolic_stream #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .ROWS      (R),
    .COLS      (C),
    .FRAC_BITS (FB)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load_matrix(load_matrix),
    .matrix_in  (matrix_in),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_vector   (s_vector),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_result   (m_result),
    .m_sat      (m_sat),
    .load_done  (load_done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [R*C*DW-1:0] fill(
      input logic [DW-1:0] v);
    logic [R*C*DW-1:0] w;
    for (int k = 0; k < R*C; k++) w[k*DW +: DW] = v;
    return w;
  endfunction

  function automatic logic [R*C*DW-1:0] diag(
      input logic [DW-1:0] v);
    logic [R*C*DW-1:0] w;
    w = '0;
    for (int i = 0; i < R; i++) w[(i*C+i)*DW +: DW] = v;
    return w;
  endfunction

  function automatic logic [C*DW-1:0] vec(
      input logic [DW-1:0] a, input logic [DW-1:0] b,
      input logic [DW-1:0] c, input logic [DW-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic void model(
      input  logic [R*C*DW-1:0] wm,
      input  logic [C*DW-1:0]   x,
      output logic [R*OW-1:0]   y,
      output logic [R-1:0]      s);
    y = '0;
    s = '0;
    for (int i = 0; i < R; i++) begin : g_r
      longint acc;
      longint sh;
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] b;
      acc = 0;
      for (int j = 0; j < C; j++) begin
        a = wm[(i*C+j)*DW +: DW];
        b = x[j*DW +: DW];
        acc += longint'(a) * longint'(b);
      end
      sh = acc >>> FB;
      if (sh > 32767) begin
        y[i*OW +: OW] = 16'h7FFF;
        s[i] = 1'b1;
      end else if (sh < -32768) begin
        y[i*OW +: OW] = 16'h8000;
        s[i] = 1'b1;
      end else begin
        y[i*OW +: OW] = sh[OW-1:0];
      end
    end
  endfunction

  task automatic single(input string tag,
                        input logic [C*DW-1:0] x,
                        input logic [R*OW-1:0] ey,
                        input logic [R-1:0]    es);
    int n;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_vector = x;
    #1;
    chk({tag, " s_ready"}, 64'(s_ready), 64'd1);
    step();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd7);
    chk({tag, " y"}, 64'(m_result), 64'(ey));
    chk({tag, " sat"}, 64'(m_sat), 64'(es));
    step();
  endtask

  task automatic load_w(input string tag,
                        input logic [R*C*DW-1:0] w);
    int n;
    matrix_in = w;
    load_matrix = 1'b1;
    step();
    load_matrix = 1'b0;
    chk({tag, " drain s_ready"}, 64'(s_ready), 64'd0);
    n = 0;
    while (!load_done && n < 50) begin
      step();
      n++;
    end
    chk({tag, " reload cycles"}, 64'(n), 64'd2);
    chk({tag, " load_done"}, 64'(load_done), 64'd1);
    chk({tag, " s_ready at done"}, 64'(s_ready), 64'd1);
    step();
    chk({tag, " load_done pulse"}, 64'(load_done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R*C*DW-1:0] wr;
    logic [R*C*DW-1:0] wa;
    logic [R*C*DW-1:0] wb;
    logic [C*DW-1:0]   xq [16];
    logic [R*OW-1:0]   ey [16];
    logic [R-1:0]      es [16];
    logic [C*DW-1:0]   xr [5];
    int sent;
    int got;
    int cyc;
    int n;
    bit reqd;
    bit ldseen;
    bit stall;

    #2;
    aresetn = 1'b0;
    repeat (3) step();
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset m_result", 64'(m_result), 64'd0);
    chk("reset m_sat", 64'(m_sat), 64'd0);
    chk("reset load_done", 64'(load_done), 64'd0);
    aresetn = 1'b1;
    #1;
    chk("reset s_ready", 64'(s_ready), 64'd1);

    single("zero W", vec(16'h1234, 16'h7FFF, 16'h8000, 16'h0001),
           '0, 3'b000);

    load_w("ident", diag(16'h4000));
    single("ident", vec(16'h1000, 16'h2000, 16'h3000, 16'h0400),
           {16'h3000, 16'h2000, 16'h1000}, 3'b000);

    load_w("neg", fill(16'hC000));
    single("neg 2000", vec(16'h2000, 16'h0, 16'h0, 16'h0),
           {3{16'hE000}}, 3'b000);
    single("neg 0001", vec(16'h0001, 16'h0, 16'h0, 16'h0),
           {3{16'hFFFF}}, 3'b000);

    load_w("satp", fill(16'h7FFF));
    single("satp", {4{16'h7FFF}}, {3{16'h7FFF}}, 3'b111);

    load_w("satn", fill(16'h8000));
    single("satn", {4{16'h7FFF}}, {3{16'h8000}}, 3'b111);

    for (int k = 0; k < R*C; k++) wr[k*DW +: DW] = DW'($urandom);
    load_w("rand", wr);
    for (int k = 0; k < 16; k++) begin
      xq[k] = {$urandom, $urandom};
      model(wr, xq[k], ey[k], es[k]);
    end
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 16 && cyc < 400) begin
      s_valid = (sent < 16);
      s_vector = xq[(sent < 16) ? sent : 15];
      m_ready = 1'($urandom_range(0, 1));
      #1;
      stall = m_valid && !m_ready;
      if (m_valid && m_ready) begin
        chk($sformatf("bp y%0d", got), 64'(m_result), 64'(ey[got]));
        chk($sformatf("bp sat%0d", got), 64'(m_sat), 64'(es[got]));
        got++;
      end
      if (s_valid && s_ready) sent++;
      step();
      cyc++;
      if (stall) begin
        chk("bp hold valid", 64'(m_valid), 64'd1);
        chk("bp hold y", 64'(m_result), 64'(ey[got]));
        chk("bp hold sat", 64'(m_sat), 64'(es[got]));
      end
    end
    chk("bp count", 64'(got), 64'd16);
    s_valid = 1'b0;
    m_ready = 1'b1;
    n = 0;
    repeat (12) begin
      step();
      if (m_valid) n++;
    end
    chk("bp no extra", 64'(n), 64'd0);

    wa = diag(16'h4000);
    wb = fill(16'hC000);
    load_w("rl A", wa);
    xr[0] = vec(16'h1000, 16'h0800, 16'h0400, 16'h0200);
    xr[1] = vec(16'h2000, 16'hF000, 16'h0100, 16'h4000);
    xr[2] = vec(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    xr[3] = vec(16'h7FFF, 16'h8000, 16'h1234, 16'h0000);
    xr[4] = vec(16'h1000, 16'h0800, 16'h0400, 16'h0200);
    for (int k = 0; k < 5; k++)
      model((k < 4) ? wa : wb, xr[k], ey[k], es[k]);
    matrix_in = wb;
    m_ready = 1'b1;
    sent = 0;
    got = 0;
    cyc = 0;
    reqd = 1'b0;
    ldseen = 1'b0;
    while (got < 5 && cyc < 100) begin
      s_valid = (sent < 5);
      s_vector = xr[(sent < 5) ? sent : 4];
      load_matrix = (sent == 3) && !reqd;
      #1;
      if (reqd && !ldseen) begin
        if (load_done) begin
          ldseen = 1'b1;
          chk("rl s_ready at done", 64'(s_ready), 64'd1);
        end else begin
          chk("rl s_ready blocked", 64'(s_ready), 64'd0);
        end
      end
      if (load_matrix) begin
        chk("rl same-edge accept", 64'(s_ready), 64'd1);
        reqd = 1'b1;
      end
      if (m_valid && m_ready) begin
        chk($sformatf("rl y%0d", got), 64'(m_result), 64'(ey[got]));
        chk($sformatf("rl sat%0d", got), 64'(m_sat), 64'(es[got]));
        got++;
      end
      if (s_valid && s_ready) sent++;
      step();
      cyc++;
    end
    load_matrix = 1'b0;
    s_valid = 1'b0;
    chk("rl count", 64'(got), 64'd5);
    chk("rl load_done seen", 64'(ldseen), 64'd1);

    m_ready = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < 5 && cyc < 50) begin
      s_valid = 1'b1;
      s_vector = xr[sent];
      #1;
      if (s_valid && s_ready) sent++;
      step();
      cyc++;
    end
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 30) begin
      step();
      n++;
    end
    chk("rst pre m_valid", 64'(m_valid), 64'd1);
    chk("rst pre y", 64'(m_result), 64'(ey[4]));
    #3;
    aresetn = 1'b0;
    #1;
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("rst m_result", 64'(m_result), 64'd0);
    chk("rst m_sat", 64'(m_sat), 64'd0);
    step();
    step();
    aresetn = 1'b1;
    m_ready = 1'b1;
    n = 0;
    repeat (15) begin
      step();
      if (m_valid) n++;
    end
    chk("rst no stale", 64'(n), 64'd0);
    single("rst zero W", vec(16'h4000, 16'h7FFF, 16'h8001, 16'h1234),
           '0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
